// File: rtl/d3_descrambler_pkg.sv
// d3_descrambler_pkg: shared state encoding and scrambler polynomial constants
package d3_descrambler_pkg;
   typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_t;
   localparam int TAP_A    = 2;
   localparam int TAP_B    = 3;
   localparam int HIST_LEN = 3;
endpackage

// File: rtl/d3_out_stage.sv
// d3_out_stage: one-entry valid/ready output register with saturating delivered-bit counter
module d3_out_stage #(
   parameter int CNT_W = 16
) (
   input  logic             d_clk,
   input  logic             d_rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic             din,
   input  logic             out_ready,
   output logic             out_valid,
   output logic             data_out,
   output logic [CNT_W-1:0] bit_cnt
);
   logic deliver;
   assign deliver = out_valid && out_ready && !flush;
   always_ff @(posedge d_clk or negedge d_rst_n) begin
      if (!d_rst_n) begin
         out_valid <= 1'b0;
         data_out  <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         if (flush)
            out_valid <= 1'b0;
         else if (load) begin
            out_valid <= 1'b1;
            data_out  <= din;
         end else if (out_ready)
            out_valid <= 1'b0;
         if (deliver && bit_cnt != '1)
            bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/d3_descrambler.sv
// d3_descrambler: self-synchronising descrambler for s[k] = d[k] ^ s[k-2] ^ s[k-3]
// with acquire/lock tracking, valid/ready output and run-length error detection.
module d3_descrambler
   import d3_descrambler_pkg::*;
#(
   parameter int MAX_RUN = 16,
   parameter int CNT_W   = 16
) (
   input  logic             d_clk,
   input  logic             d_rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             scr_in,
   output logic             in_ready,
   output logic             out_valid,
   output logic             data_out,
   input  logic             out_ready,
   output logic             locked,
   output logic             run_err,
   output logic [CNT_W-1:0] bit_cnt
);
   state_t              state, state_nx;
   logic [1:0]          fill;
   logic [HIST_LEN-1:0] hist;
   logic                accept, load, dbit, deliver, last_bit;
   logic [7:0]          run_cnt, run_nx;

   // reset gates in_ready directly so the source is stalled while d_rst_n is low
   assign in_ready = d_rst_n && (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign dbit     = scr_in ^ hist[TAP_A-1] ^ hist[TAP_B-1];
   assign deliver  = out_valid && out_ready && !flush;

   always_ff @(posedge d_clk or negedge d_rst_n) begin
      if (!d_rst_n)
         state <= ACQUIRE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = flush ? ACQUIRE :
                 (state == ACQUIRE && accept && fill == 2'(HIST_LEN - 1)) ? LOCKED : state;
   end

   always_comb begin
      locked = state == LOCKED;
      load   = accept && state == LOCKED;
   end

   always_ff @(posedge d_clk or negedge d_rst_n) begin
      if (!d_rst_n) begin
         fill <= 2'd0;
         hist <= '0;
      end else if (flush) begin
         fill <= 2'd0;
         hist <= '0;
      end else if (accept) begin
         hist <= {hist[HIST_LEN-2:0], scr_in};
         if (state == ACQUIRE)
            fill <= fill + 2'd1;
      end
   end

   // a zero count means nothing delivered since reset/flush, so the next bit starts a run
   always_comb begin
      run_nx = (run_cnt == 8'd0 || data_out != last_bit) ? 8'd1 :
               (run_cnt == 8'hff) ? run_cnt : run_cnt + 8'd1;
   end

   always_ff @(posedge d_clk or negedge d_rst_n) begin
      if (!d_rst_n) begin
         run_cnt  <= 8'd0;
         last_bit <= 1'b0;
         run_err  <= 1'b0;
      end else if (flush) begin
         run_cnt  <= 8'd0;
         last_bit <= 1'b0;
         run_err  <= 1'b0;
      end else if (deliver) begin
         run_cnt  <= run_nx;
         last_bit <= data_out;
         if (run_nx == 8'(MAX_RUN))
            run_err <= 1'b1;
      end
   end

   d3_out_stage #(.CNT_W(CNT_W)) u_out (
      .d_clk     (d_clk),
      .d_rst_n   (d_rst_n),
      .flush     (flush),
      .load      (load),
      .din       (dbit),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .data_out  (data_out),
      .bit_cnt   (bit_cnt)
   );
endmodule

// File: tb/tb_d3_descrambler.sv
// tb_d3_descrambler: directed checks of acquisition, loopback, backpressure, flush,
// run detection and asynchronous reset against a reference scrambler.
module tb_d3_descrambler;
   logic        d_clk = 0, d_rst_n = 0, flush = 0, in_valid = 0, scr_in = 0, out_ready = 1;
   logic        in_ready, out_valid, data_out, locked, run_err;
   logic [15:0] bit_cnt;
   int          total = 0, bad = 0, n_acc = 0;
   bit          got[$], exp_q[$];
   logic [2:0]  sh = 3'b000;

   d3_descrambler #(.MAX_RUN(16), .CNT_W(16)) dut (
      .d_clk(d_clk), .d_rst_n(d_rst_n), .flush(flush), .in_valid(in_valid), .scr_in(scr_in),
      .in_ready(in_ready), .out_valid(out_valid), .data_out(data_out), .out_ready(out_ready),
      .locked(locked), .run_err(run_err), .bit_cnt(bit_cnt)
   );

   always #5 d_clk = ~d_clk;

   always @(posedge d_clk)
      if (d_rst_n && out_valid && out_ready && !flush) got.push_back(data_out);

   task automatic cycle(input logic v, input logic s, input logic ordy, input logic fl, output logic acc);
      @(negedge d_clk);
      in_valid = v; scr_in = s; out_ready = ordy; flush = fl;
      #1 acc = in_valid && in_ready;
      @(posedge d_clk);
      #1;
   endtask

   // reference scrambler: line bit advances only when the descrambler accepts it
   task automatic send(input logic d, input logic ordy, output logic acc);
      logic s;
      s = d ^ sh[1] ^ sh[2];
      cycle(1'b1, s, ordy, 1'b0, acc);
      if (acc) begin
         sh = {sh[1:0], s};
         if (n_acc >= 3) exp_q.push_back(d);
         n_acc++;
      end
   endtask

   task automatic start();
      got.delete(); exp_q.delete(); n_acc = 0;
   endtask

   task automatic apply_reset();
      @(negedge d_clk);
      d_rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
      @(posedge d_clk);
      @(negedge d_clk);
      d_rst_n = 1;
      sh = 3'b000;
      start();
   endtask

   task automatic test_reset();
      d_rst_n = 0; in_valid = 0; flush = 0; out_ready = 1;
      #3;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (data_out !== 1'b0) begin bad++; $display("FAIL rst_data_out got=%b want=0", data_out); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", locked); end
      total++; if (run_err !== 1'b0) begin bad++; $display("FAIL rst_run_err got=%b want=0", run_err); end
      total++; if (bit_cnt !== 16'd0) begin bad++; $display("FAIL rst_bit_cnt got=%0d want=0", bit_cnt); end
      repeat (2) @(posedge d_clk);
      @(negedge d_clk);
      d_rst_n = 1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b want=1", in_ready); end
      start();
   endtask

   task automatic test_basic();
      bit   pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic acc;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, pat[i], 1'b1, 1'b0, acc);
         total++; if (acc !== 1'b1) begin bad++; $display("FAIL basic_accept[%0d] got=%b want=1", i, acc); end
         total++; if (locked !== (i >= 2)) begin bad++; $display("FAIL basic_locked[%0d] got=%b want=%b", i, locked, i >= 2); end
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
      total++; if (got.size() != 5) begin bad++; $display("FAIL basic_count got=%0d want=5", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         total++; if (got[i] !== 1'b0) begin bad++; $display("FAIL basic_data[%0d] got=%b want=0", i, got[i]); end
      end
      total++; if (bit_cnt !== 16'd5) begin bad++; $display("FAIL basic_bit_cnt got=%0d want=5", bit_cnt); end
   endtask

   task automatic test_loopback();
      logic acc, d, last;
      int   run;
      apply_reset();
      last = 0; run = 0;
      for (int i = 0; i < 200; i++) begin
         d = 1'($urandom_range(0, 1));
         if (run >= 14 && d == last) d = ~d;
         run = (i > 0 && d == last) ? run + 1 : 1;
         last = d;
         send(d, 1'b1, acc);
         total++; if (acc !== 1'b1) begin bad++; $display("FAIL lb_b2b_accept[%0d] got=%b want=1", i, acc); end
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL lb_count got=%0d want=%0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL lb_data[%0d] got=%b want=%b", i, got[i], exp_q[i]); end
      end
      total++; if (bit_cnt !== 16'd197) begin bad++; $display("FAIL lb_bit_cnt got=%0d want=197", bit_cnt); end
      total++; if (run_err !== 1'b0) begin bad++; $display("FAIL lb_run_err got=%b want=0", run_err); end
   endtask

   task automatic test_backpressure();
      logic acc, d, ordy, hold;
      apply_reset();
      hold = 0;
      for (int i = 0; i < 40; i++) begin
         ordy = !(i >= 15 && i < 19);
         d = 1'($urandom_range(0, 1));
         send(d, ordy, acc);
         if (!ordy) begin
            total++; if (acc !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, acc); end
            total++; if (out_valid !== 1'b1 || data_out !== hold) begin
               bad++; $display("FAIL bp_hold[%0d] got=%b/%b want=1/%b", i, out_valid, data_out, hold);
            end
         end
         if (i == 14) hold = data_out;
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL bp_data[%0d] got=%b want=%b", i, got[i], exp_q[i]); end
      end
      total++; if (bit_cnt !== 16'(exp_q.size())) begin bad++; $display("FAIL bp_bit_cnt got=%0d want=%0d", bit_cnt, exp_q.size()); end
   endtask

   task automatic test_flush();
      logic        acc;
      logic [15:0] cnt_before;
      apply_reset();
      for (int i = 0; i < 6; i++) send(1'($urandom_range(0, 1)), 1'b1, acc);
      total++; if (out_valid !== 1'b1 || locked !== 1'b1) begin
         bad++; $display("FAIL fl_pre got=%b/%b want=1/1", out_valid, locked);
      end
      cnt_before = bit_cnt;
      cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
      total++; if (acc !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%b want=0", acc); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_out_valid got=%b want=0", out_valid); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL fl_locked got=%b want=0", locked); end
      total++; if (bit_cnt !== cnt_before) begin bad++; $display("FAIL fl_bit_cnt got=%0d want=%0d", bit_cnt, cnt_before); end
      start();
      for (int j = 0; j < 3; j++) begin
         send(1'($urandom_range(0, 1)), 1'b1, acc);
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_drop[%0d] got=%b want=0", j, out_valid); end
         total++; if (locked !== (j == 2)) begin bad++; $display("FAIL fl_relock[%0d] got=%b want=%b", j, locked, j == 2); end
      end
      send(1'b1, 1'b1, acc);
      send(1'b0, 1'b1, acc);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
      total++; if (got.size() != 2) begin bad++; $display("FAIL fl_count got=%0d want=2", got.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL fl_data[%0d] got=%b want=%b", i, got[i], exp_q[i]); end
      end
      total++; if (bit_cnt !== cnt_before + 16'd2) begin bad++; $display("FAIL fl_bit_cnt_after got=%0d want=%0d", bit_cnt, cnt_before + 16'd2); end
   endtask

   task automatic test_run();
      logic acc;
      bit   seen15, seen16;
      apply_reset();
      seen15 = 0; seen16 = 0;
      send(1'b0, 1'b1, acc);
      send(1'b1, 1'b1, acc);
      send(1'b0, 1'b1, acc);
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 1'b1, acc);
         if (got.size() == 15 && !seen15) begin
            seen15 = 1;
            total++; if (run_err !== 1'b0) begin bad++; $display("FAIL run_15 got=%b want=0", run_err); end
         end
         if (got.size() == 16 && !seen16) begin
            seen16 = 1;
            total++; if (run_err !== 1'b1) begin bad++; $display("FAIL run_16 got=%b want=1", run_err); end
         end
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0, acc);
      total++; if (!(seen15 && seen16)) begin bad++; $display("FAIL run_seen got=%b%b want=11", seen15, seen16); end
      total++; if (got.size() != 20) begin bad++; $display("FAIL run_count got=%0d want=20", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         total++; if (got[i] !== 1'b1) begin bad++; $display("FAIL run_data[%0d] got=%b want=1", i, got[i]); end
      end
      total++; if (run_err !== 1'b1) begin bad++; $display("FAIL run_sticky got=%b want=1", run_err); end
      cycle(1'b0, 1'b0, 1'b1, 1'b1, acc);
      total++; if (run_err !== 1'b0) begin bad++; $display("FAIL run_flush got=%b want=0", run_err); end
   endtask

   task automatic test_async_reset();
      logic acc;
      apply_reset();
      for (int i = 0; i < 6; i++) send(1'($urandom_range(0, 1)), 1'b1, acc);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, acc);
      total++; if (locked !== 1'b1 || out_valid !== 1'b1 || bit_cnt === 16'd0) begin
         bad++; $display("FAIL ar_pre got=%b/%b/%0d want=1/1/nonzero", locked, out_valid, bit_cnt);
      end
      @(posedge d_clk);
      #3 d_rst_n = 0;
      #1;
      total++; if (out_valid !== 1'b0 || data_out !== 1'b0) begin bad++; $display("FAIL ar_out got=%b/%b want=0/0", out_valid, data_out); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL ar_locked got=%b want=0", locked); end
      total++; if (run_err !== 1'b0) begin bad++; $display("FAIL ar_run_err got=%b want=0", run_err); end
      total++; if (bit_cnt !== 16'd0) begin bad++; $display("FAIL ar_bit_cnt got=%0d want=0", bit_cnt); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_in_ready got=%b want=0", in_ready); end
      @(negedge d_clk);
      d_rst_n = 1;
      start();
      send(1'b1, 1'b1, acc);
      total++; if (acc !== 1'b1 || locked !== 1'b0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL ar_reacquire got=%b/%b/%b want=1/0/0", acc, locked, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loopback();
      test_backpressure();
      test_flush();
      test_run();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/d3_descrambler.md
D3_DESCRAMBLER -- requirements
Module: d3_descrambler

Interface
REQ-001 Parameter: MAX_RUN, default 16, run length of identical descrambled bits that sets run_err; legal range 2..255.
REQ-002 Parameter: CNT_W, default 16, width of delivered-bit counter.
REQ-003 d_clk  input  1  clock; all state updates on its rising edge.
REQ-004 d_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous re-acquire request.
REQ-006 in_valid  input  1  scr_in carries a line bit this cycle.
REQ-007 scr_in  input  1  scrambled line bit.
REQ-008 in_ready  output  1  block accepts the input bit this cycle.
REQ-009 out_valid  output  1  data_out holds a descrambled bit.
REQ-010 data_out  output  1  descrambled bit.
REQ-011 out_ready  input  1  sink accepts data_out this cycle.
REQ-012 locked  output  1  history filled; output bits are trustworthy.
REQ-013 run_err  output  1  sticky flag: MAX_RUN identical descrambled bits were seen.
REQ-014 bit_cnt  output  CNT_W  count of delivered bits, saturating.

Function
REQ-015 The descrambler SHALL invert the recursive scrambler s[k] = d[k] ^ s[k-2] ^ s[k-3].
REQ-016 History register H0/H1/H2 SHALL hold r[k-1]/r[k-2]/r[k-3].
REQ-017 The descrambled bit SHALL be scr_in ^ H1 ^ H2.
REQ-018 An input bit is accepted when in_valid && in_ready.
- On accept: H2<=H1, H1<=H0, H0<=scr_in.
- History SHALL NOT change on any other cycle.
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-020 Output stage is one register.
- Latency from accept to out_valid is 1 cycle.
- data_out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-021 The FSM SHALL have two states, ACQUIRE and LOCKED; a 2-bit fill counter (0..3) counts accepted bits in ACQUIRE.
REQ-022 ACQUIRE: accepted bits update history only; no output is produced; ACQUIRE->LOCKED when the 3rd bit is accepted.
REQ-023 LOCKED: every accepted bit SHALL load the output register.
REQ-024 locked SHALL be 1 exactly when the state is LOCKED.
REQ-025 A cycle with flush=1 SHALL act as follows:
- go to ACQUIRE;
- clear history, fill counter, out_valid, run counter and run_err;
- drop any pending output;
- leave bit_cnt unchanged.
REQ-026 Flush has priority over a simultaneous accept or output handshake.
REQ-027 bit_cnt SHALL increment on each out_valid && out_ready and saturate at all-ones.
REQ-028 Run counter (8 bits) tracks consecutive equal delivered bits.
- It resets to 1 on a bit change.
- run_err SHALL set when the count reaches MAX_RUN and SHALL stay set until flush or reset.
REQ-029 Back-to-back accepts at full rate SHALL be supported while out_ready=1 (one bit per cycle, no bubbles).

Reset
REQ-030 Asynchronous assertion SHALL force the following values:
- state=ACQUIRE, fill counter=0;
- H0=H1=H2=0;
- out_valid=0, data_out=0, locked=0;
- run_err=0, run counter=0, bit_cnt=0.
REQ-031 Reset mid-stream SHALL discard the pending output; after deassertion the block re-acquires from ACQUIRE.
REQ-032 in_ready SHALL be 0 during reset and 1 on the first cycle after deassertion.

Structure
REQ-033 A shared package SHALL hold the following:
- the state enum (ACQUIRE, LOCKED);
- the feedback tap constants (taps 2 and 3);
- the history length constant (3).
REQ-034 Sub-module d3_out_stage SHALL implement the 1-entry valid/ready output register with bit_cnt.

Verification
REQ-035 Reset then feed 1,0,1,1,1,0,0,1 with out_ready=1. Required:
- first 3 bits dropped;
- locked rises after the 3rd accept;
- outputs 0,0,0,0,0;
- bit_cnt=5.
REQ-036 Loopback: scrambler and descrambler both reset, 200 random bits fed. Required: descrambled stream equals source delayed by the link, after the first 3 bits; run_err stays 0.
REQ-037 Backpressure: out_ready=0 for 4 cycles mid-stream. Required:
- in_ready=0 during the stall;
- data_out held;
- no bit lost or duplicated;
- bit_cnt matches accepted LOCKED bits.
REQ-038 Flush asserted with out_valid=1 and in_valid=1. Required:
- out_valid=0 and locked=0 next cycle;
- the next 3 accepts are dropped;
- bit_cnt unchanged.
REQ-039 Feed a line pattern that descrambles to 16 ones (MAX_RUN=16). Required: run_err=1 on the 16th delivered bit; run_err stays set; flush clears it.
REQ-040 Assert d_rst_n=0 asynchronously mid-cycle while LOCKED. Required: all outputs at reset values immediately, without waiting for a clock edge.
